// File: rtl/ahb_ap_ctrl.sv
// AHB access-port command controller: decodes a 42-bit command word into
// single AHB read/write strobes and pushes read data into a response buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   en, cmd[41:0]             command strobe and word (sampled in IDLE only)
//   busy, rdata[31:0]         AHB master status and read data
//   full                      response buffer full
//   ren, wen_ahb              one-cycle AHB read / write strobes
//   addr, wdata_ahb, size     AHB address, write data and transfer size
//   wen_buf, wdata_buf        response buffer push and pushed data
//   ack, ctrl_busy, err       completion pulse, busy flag, last-command status
module ahb_ap_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [41:0] cmd,
  input  logic        busy,
  input  logic [31:0] rdata,
  input  logic        full,
  output logic        ren,
  output logic        wen_ahb,
  output logic [31:0] addr,
  output logic [31:0] wdata_ahb,
  output logic [1:0]  size,
  output logic        wen_buf,
  output logic [31:0] wdata_buf,
  output logic        ack,
  output logic        ctrl_busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]    op_q, op_d;
  logic          ai_q, ai_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_ahb_q, wdata_ahb_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   wdata_buf_q, wdata_buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          cbusy_q, cbusy_d;
  logic          err_q, err_d;
  // Failure of the command itself (illegal or timed out); unlike err it
  // is not touched by a dropped command, so it alone gates autoinc.
  logic          fail_q, fail_d;

  logic [1:0]  cmd_op;
  logic        cmd_ai;
  logic [1:0]  cmd_sz;
  logic [31:0] cmd_pl;
  logic        misalign;
  logic        illegal;
  logic        wait_tmo;
  logic        unused_cmd;

  assign cmd_op = cmd[41:40];
  assign cmd_ai = cmd[39];
  assign cmd_sz = cmd[38:37];
  assign cmd_pl = cmd[31:0];
  assign unused_cmd = ^cmd[36:32];

  assign misalign = (cmd_sz == 2'b01 && addr_q[0]) ||
                    (cmd_sz == 2'b10 && addr_q[1:0] != 2'b00);
  assign illegal  = (cmd_sz == 2'b11) || misalign;
  assign wait_tmo = busy && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          if (!cmd_op[1] || illegal) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!busy) begin
          state_d = (op_q == OP_RD) ? S_PUSH : S_DONE;
        end else if (wait_tmo) begin
          state_d = S_DONE;
        end
      end
      S_PUSH: begin
        if (!full) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe outputs, decoded from state
  always_comb begin
    ren     = 1'b0;
    wen_ahb = 1'b0;
    wen_buf = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        ren     = (op_q == OP_RD);
        wen_ahb = (op_q == OP_WR);
      end
      S_PUSH:  wen_buf = !full;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    op_d        = op_q;
    ai_d        = ai_q;
    addr_d      = addr_q;
    wdata_ahb_d = wdata_ahb_q;
    size_d      = size_q;
    wdata_buf_d = wdata_buf_q;
    cnt_d       = cnt_q;
    ack_d       = 1'b0;
    cbusy_d     = cbusy_q;
    err_d       = err_q;
    fail_d      = fail_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          op_d    = cmd_op;
          ai_d    = cmd_ai;
          cbusy_d = 1'b1;
          err_d   = 1'b0;
          fail_d  = 1'b0;
          if (cmd_op == OP_SET) begin
            addr_d = cmd_pl;
          end else if (cmd_op != OP_NOP) begin
            if (illegal) begin
              err_d  = 1'b1;
              fail_d = 1'b1;
            end else begin
              size_d = cmd_sz;
              if (cmd_op == OP_WR) begin
                wdata_ahb_d = cmd_pl;
              end
            end
          end
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT: begin
        if (!busy) begin
          if (op_q == OP_RD) begin
            wdata_buf_d = rdata;
          end
        end else if (wait_tmo) begin
          err_d  = 1'b1;
          fail_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PUSH: ;
      S_DONE: begin
        ack_d   = 1'b1;
        cbusy_d = 1'b0;
        if (op_q[1] && ai_q && !fail_q) begin
          addr_d = addr_q + (32'd1 << size_q);
        end
      end
      default: ;
    endcase
    // A command offered while one is in flight is dropped and flagged.
    if (en && state_q != S_IDLE) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_NOP;
      ai_q        <= 1'b0;
      addr_q      <= '0;
      wdata_ahb_q <= '0;
      size_q      <= '0;
      wdata_buf_q <= '0;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      cbusy_q     <= 1'b0;
      err_q       <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      ai_q        <= ai_d;
      addr_q      <= addr_d;
      wdata_ahb_q <= wdata_ahb_d;
      size_q      <= size_d;
      wdata_buf_q <= wdata_buf_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      cbusy_q     <= cbusy_d;
      err_q       <= err_d;
      fail_q      <= fail_d;
    end
  end

  assign addr      = addr_q;
  assign wdata_ahb = wdata_ahb_q;
  assign size      = size_q;
  assign wdata_buf = wdata_buf_q;
  assign ack       = ack_q;
  assign ctrl_busy = cbusy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ahb_ap_ctrl.sv
// Directed bench for ahb_ap_ctrl: a per-cycle vector table for the basic
// flow, then hand-written sequences for timeout, stall, wrap and reset.
module tb_ahb_ap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [41:0] cmd;
  logic        busy;
  logic [31:0] rdata;
  logic        full;
  logic        ren, wen_ahb, wen_buf, ack, ctrl_busy, err;
  logic [31:0] addr, wdata_ahb, wdata_buf;
  logic [1:0]  size;

  int n_chk = 0;
  int n_fail = 0;

  ahb_ap_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .busy(busy),
    .rdata(rdata), .full(full), .ren(ren), .wen_ahb(wen_ahb),
    .addr(addr), .wdata_ahb(wdata_ahb), .size(size),
    .wen_buf(wen_buf), .wdata_buf(wdata_buf), .ack(ack),
    .ctrl_busy(ctrl_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [41:0] cmd;
    logic        busy;
    logic [31:0] rdata;
    logic        full;
    logic        ren, wa, wb, ack, cb, err;
    logic [31:0] addr;
    logic [31:0] wdb;
  } vec_t;

  vec_t tbl[21];

  function automatic logic [41:0] mk(input logic [1:0] op, input logic ai,
                                     input logic [1:0] sz,
                                     input logic [31:0] pl);
    return {op, ai, sz, 5'b0, pl};
  endfunction

  function automatic vec_t v(input logic e, input logic [41:0] c,
                             input logic b, input logic [31:0] rd,
                             input logic [5:0] o, input logic [31:0] a,
                             input logic [31:0] wdb);
    vec_t r;
    r.en = e; r.cmd = c; r.busy = b; r.rdata = rd; r.full = 1'b0;
    {r.ren, r.wa, r.wb, r.ack, r.cb, r.err} = o;
    r.addr = a; r.wdb = wdb;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [41:0] c, input logic b,
                     input logic [31:0] rd, input logic f);
    @(negedge clk);
    en = e; cmd = c; busy = b; rdata = rd; full = f;
    #1;
    chk("onehot", 32'($countones({ren, wen_ahb, wen_buf, ack}) > 1), 0);
  endtask

  // Cycle 0 carries en; busy is high for cycles bf..bt, full for 1..ft,
  // and a stray en repeats cmd at cycle st. Stops on ack or a budget.
  task automatic run_op(input logic [41:0] c, input int bf, input int bt,
                        input int ft, input int st, input logic [31:0] rd,
                        output int ack_at, output int n_wa,
                        output int n_rd, output int n_wb,
                        output int wb_at, output logic [31:0] wb_data);
    ack_at = -1; n_wa = 0; n_rd = 0; n_wb = 0; wb_at = -1; wb_data = '0;
    cyc(1'b1, c, 1'b0, rd, 1'b0);
    for (int i = 1; i < 60; i++) begin
      cyc(i == st, c, (i >= bf && i <= bt), rd, (i <= ft));
      if (wen_ahb) n_wa++;
      if (ren) n_rd++;
      if (wen_buf) begin
        n_wb++; wb_at = i; wb_data = wdata_buf;
      end
      if (ack) begin
        ack_at = i;
        break;
      end
    end
  endtask

  task automatic set_addr(input logic [31:0] a);
    int aa, w, r, b, ba;
    logic [31:0] bd;
    run_op(mk(2'b01, 1'b0, 2'b00, a), 99, 0, 0, -1, 0,
           aa, w, r, b, ba, bd);
    chk("set_addr ack", aa, 2);
    chk("set_addr val", addr, a);
  endtask

  initial begin
    int aa, w, r, b, ba, hits;
    logic [31:0] bd;
    tbl[0]  = v(1, mk(2'b01,0,2'b00,32'h1000), 0, 0, 6'b000000, 32'h0, 32'h0);
    tbl[1]  = v(0, 0, 0, 0, 6'b000010, 32'h1000, 32'h0);
    tbl[2]  = v(0, 0, 0, 0, 6'b000100, 32'h1000, 32'h0);
    tbl[3]  = v(1, mk(2'b11,1,2'b10,0), 0, 0, 6'b000000, 32'h1000, 32'h0);
    tbl[4]  = v(0, 0, 0, 0, 6'b100010, 32'h1000, 32'h0);
    tbl[5]  = v(0, 0, 1, 0, 6'b000010, 32'h1000, 32'h0);
    tbl[6]  = v(0, 0, 1, 0, 6'b000010, 32'h1000, 32'h0);
    tbl[7]  = v(0, 0, 1, 0, 6'b000010, 32'h1000, 32'h0);
    tbl[8]  = v(0, 0, 0, 32'hDEADBEEF, 6'b000010, 32'h1000, 32'h0);
    tbl[9]  = v(0, 0, 0, 0, 6'b001010, 32'h1000, 32'hDEADBEEF);
    tbl[10] = v(0, 0, 0, 0, 6'b000010, 32'h1000, 32'hDEADBEEF);
    tbl[11] = v(0, 0, 0, 0, 6'b000100, 32'h1004, 32'hDEADBEEF);
    tbl[12] = v(1, mk(2'b01,0,2'b00,32'h2001), 0, 0, 6'b000000,
                32'h1004, 32'hDEADBEEF);
    tbl[13] = v(0, 0, 0, 0, 6'b000010, 32'h2001, 32'hDEADBEEF);
    tbl[14] = v(0, 0, 0, 0, 6'b000100, 32'h2001, 32'hDEADBEEF);
    tbl[15] = v(1, mk(2'b10,0,2'b01,32'hABCD), 0, 0, 6'b000000,
                32'h2001, 32'hDEADBEEF);
    tbl[16] = v(0, 0, 0, 0, 6'b000011, 32'h2001, 32'hDEADBEEF);
    tbl[17] = v(0, 0, 0, 0, 6'b000101, 32'h2001, 32'hDEADBEEF);
    tbl[18] = v(1, mk(2'b00,0,2'b00,0), 0, 0, 6'b000001,
                32'h2001, 32'hDEADBEEF);
    tbl[19] = v(0, 0, 0, 0, 6'b000010, 32'h2001, 32'hDEADBEEF);
    tbl[20] = v(0, 0, 0, 0, 6'b000100, 32'h2001, 32'hDEADBEEF);

    rst = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst outs", {26'b0, ren, wen_ahb, wen_buf, ack, ctrl_busy, err}, 0);
    chk("rst addr", addr, 0);
    chk("rst wdb", wdata_buf, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].cmd, tbl[i].busy, tbl[i].rdata, tbl[i].full);
      chk($sformatf("r%0d ren", i), ren, tbl[i].ren);
      chk($sformatf("r%0d wen_ahb", i), wen_ahb, tbl[i].wa);
      chk($sformatf("r%0d wen_buf", i), wen_buf, tbl[i].wb);
      chk($sformatf("r%0d ack", i), ack, tbl[i].ack);
      chk($sformatf("r%0d ctrl_busy", i), ctrl_busy, tbl[i].cb);
      chk($sformatf("r%0d err", i), err, tbl[i].err);
      chk($sformatf("r%0d addr", i), addr, tbl[i].addr);
      chk($sformatf("r%0d wdata_buf", i), wdata_buf, tbl[i].wdb);
    end

    // Write with busy stuck high: 8 WAIT cycles then abort
    set_addr(32'h3000);
    run_op(mk(2'b10, 1'b1, 2'b10, 32'h55), 2, 1000, 0, -1, 0,
           aa, w, r, b, ba, bd);
    chk("tmo ack_at", aa, 11);
    chk("tmo wen_ahb", w, 1);
    chk("tmo err", err, 1);
    chk("tmo addr", addr, 32'h3000);
    chk("tmo wdata_ahb", wdata_ahb, 32'h55);
    chk("tmo size", size, 2);

    // Read with buffer full for 10 cycles after busy drops
    set_addr(32'h4000);
    run_op(mk(2'b11, 1'b0, 2'b10, 0), 2, 2, 12, -1, 32'h12345678,
           aa, w, r, b, ba, bd);
    chk("full ren", r, 1);
    chk("full n_wb", b, 1);
    chk("full wb_at", ba, 13);
    chk("full wb_data", bd, 32'h12345678);
    chk("full ack_at", aa, 15);
    chk("full err", err, 0);
    chk("full addr", addr, 32'h4000);

    // Autoinc wrap at the top of the address space
    set_addr(32'hFFFFFFFC);
    run_op(mk(2'b10, 1'b1, 2'b10, 32'hA5A5A5A5), 2, 2, 0, -1, 0,
           aa, w, r, b, ba, bd);
    chk("wrap ack_at", aa, 5);
    chk("wrap wen_ahb", w, 1);
    chk("wrap addr", addr, 0);
    chk("wrap err", err, 0);

    // Second command offered during WAIT is dropped
    set_addr(32'h5000);
    run_op(mk(2'b10, 1'b0, 2'b10, 32'h1), 2, 4, 0, 3, 0,
           aa, w, r, b, ba, bd);
    chk("stray ack_at", aa, 7);
    chk("stray wen_ahb", w, 1);
    chk("stray err", err, 1);
    chk("stray addr", addr, 32'h5000);

    // Reset while waiting on the bus
    set_addr(32'h6000);
    cyc(1, mk(2'b11, 1'b0, 2'b10, 0), 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rstw ren", ren, 1);
    rst = 1'b1;
    cyc(0, 0, 1, 0, 0);
    rst = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("rstw outs", {26'b0, ren, wen_ahb, wen_buf, ack, ctrl_busy, err}, 0);
    chk("rstw addr", addr, 0);
    chk("rstw wdata", {wdata_ahb | wdata_buf}, 0);
    chk("rstw size", size, 0);
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 32'hCAFE, 0);
      if (ren || wen_ahb || wen_buf || ack) hits++;
    end
    chk("rstw quiet", hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ap_ctrl.md
AHB_AP_CTRL -- requirements
Module: ahb_ap_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before a transfer is aborted.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 en  in  1  one-cycle command strobe, already synchronized into the clk domain.
REQ-005 cmd  in  42  command word; sampled only when en=1 in IDLE.
REQ-006 busy  in  1  AHB master transfer in progress.
REQ-007 rdata  in  32  AHB read data; valid on the first cycle busy=0 after a read strobe.
REQ-008 full  in  1  response buffer full.
REQ-009 ren / wen_ahb  out  1 each  one-cycle AHB read / write request strobes.
REQ-010 addr  out  32  AHB address; wdata_ahb out 32 write data; size out 2 transfer size.
REQ-011 wen_buf  out  1  response buffer push; wdata_buf out 32 data pushed.
REQ-012 ack  out  1  one-cycle command-complete pulse; ctrl_busy out 1 high from command accept until ack; err out 1 status of the last command.

Function
REQ-013 cmd fields: [41:40] op (00 NOP, 01 SET_ADDR, 10 WRITE, 11 READ); [39] autoinc; [38:37] size (00 byte, 01 half, 10 word, 11 illegal); [36:32] ignored; [31:0] payload.
REQ-014 FSM states: IDLE, ISSUE, WAIT, PUSH, DONE.
REQ-015 IDLE + en=1: latch cmd, clear err, set ctrl_busy; next state depends on op, per REQ-016 to REQ-018.
REQ-016 NOP goes to DONE; SET_ADDR loads addr<=payload, then goes to DONE.
REQ-017 WRITE/READ with size=11, or misaligned (half with addr[0]=1; word with addr[1:0]!=0): set err, go to DONE, issue no AHB strobe.
REQ-018 Valid WRITE/READ: go to ISSUE; for WRITE, wdata_ahb<=payload; size output<=cmd size.
REQ-019 ISSUE lasts exactly one cycle: wen_ahb=1 (WRITE) or ren=1 (READ); next state WAIT.
REQ-020 The AHB master asserts busy no later than the cycle after the strobe; WAIT exits on the first cycle with busy=0.
REQ-021 READ exit from WAIT: capture rdata, go to PUSH; WRITE exit from WAIT: go to DONE.
REQ-022 The WAIT cycle counter resets on entry; when it reaches TIMEOUT with busy still 1: set err, go to DONE, discard read data.
REQ-023 PUSH: if full=0, drive wen_buf=1 with wdata_buf=captured rdata for one cycle, then go to DONE.
REQ-024 PUSH with full=1: stall with wen_buf=0, no timeout applies.
REQ-025 DONE lasts one cycle: ack=1 and ctrl_busy=0 from the next cycle; next state IDLE.
REQ-026 In DONE, if a WRITE/READ completed with autoinc=1 and err=0: addr<=addr+(1<<size), 32-bit wrap-around (0xFFFFFFFC+4 -> 0x00000000).
REQ-027 en=1 in any state other than IDLE (including the DONE cycle): command dropped, err set; the current operation continues unaffected.
REQ-028 err holds its value from ack until the next accepted command.
REQ-029 The end-to-end latency of a NOP is en to ack = 2 cycles.
REQ-030 At most one of ren, wen_ahb, wen_buf, ack is high in any cycle.

Reset
REQ-031 rst=1 at a clock edge forces IDLE and clears all of the following: addr, wdata_ahb, wdata_buf, size, timeout counter, ren, wen_ahb, wen_buf, ack, ctrl_busy, err.
REQ-032 Reset mid-operation (ISSUE, WAIT or PUSH): no strobe, push or ack is produced after the reset edge, and the pending command is discarded.

Verification
REQ-033 SET_ADDR payload 0x1000, then READ word autoinc; busy high 3 cycles, rdata 0xDEADBEEF -> ren pulses once with addr 0x1000; wen_buf with 0xDEADBEEF; ack; addr becomes 0x1004; err=0.
REQ-034 WRITE half payload 0x0000ABCD at addr 0x2001 -> no wen_ahb, ack 2 cycles after en, err=1, addr unchanged.
REQ-035 READ with full held high 10 cycles after busy drops -> wen_buf only after full=0; ack the following cycle; no timeout.
REQ-036 WRITE with busy stuck high, TIMEOUT=8 -> ack after 8 WAIT cycles, err=1, addr not incremented.
REQ-037 addr 0xFFFFFFFC, WRITE word autoinc -> addr 0x00000000 after ack; second en during WAIT -> err=1 and exactly one wen_ahb.
REQ-038 rst asserted in WAIT -> next cycle state IDLE, all outputs 0; busy falling afterwards causes no wen_buf or ack.
